// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the multiply/divide unit: funct codes, R-type ALU op,
// FSM encoding and default widths.
package muldiv_unit_pkg;

    localparam int DEFAULT_DATA_WIDTH          = 32;
    localparam int DEFAULT_ALU_OP_BUS_WIDTH    = 2;
    localparam int DEFAULT_ALU_FUNCT_BUS_WIDTH = 6;

    // Main-control ALU op that selects the funct field decode.
    localparam logic [1:0] CODE_ALU_CTR_R_TYPE = 2'b10;

    localparam logic [5:0] CODE_FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] CODE_FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] CODE_FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] CODE_FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] CODE_FUNCT_MULT  = 6'h18;
    localparam logic [5:0] CODE_FUNCT_MULTU = 6'h19;
    localparam logic [5:0] CODE_FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] CODE_FUNCT_DIVU  = 6'h1B;

    localparam int STATE_BUS_WIDTH = 2;

    typedef enum logic [STATE_BUS_WIDTH-1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_decoder.sv
// Combinational funct/alu_op decode into one-hot HI/LO operation flags.
module muldiv_decoder
    import muldiv_unit_pkg::*;
#(
    parameter int ALU_OP_BUS_WIDTH    = DEFAULT_ALU_OP_BUS_WIDTH,
    parameter int ALU_FUNCT_BUS_WIDTH = DEFAULT_ALU_FUNCT_BUS_WIDTH
) (
    input  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_op,
    input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
    output logic                           o_is_mul,
    output logic                           o_is_div,
    output logic                           o_is_signed,
    output logic                           o_is_mfhi,
    output logic                           o_is_mflo,
    output logic                           o_is_mthi,
    output logic                           o_is_mtlo
);

    always_comb begin
        o_is_mul    = 1'b0;
        o_is_div    = 1'b0;
        o_is_signed = 1'b0;
        o_is_mfhi   = 1'b0;
        o_is_mflo   = 1'b0;
        o_is_mthi   = 1'b0;
        o_is_mtlo   = 1'b0;
        if (i_alu_op == ALU_OP_BUS_WIDTH'(CODE_ALU_CTR_R_TYPE)) begin
            case (i_funct)
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_MFHI):  o_is_mfhi = 1'b1;
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_MTHI):  o_is_mthi = 1'b1;
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_MFLO):  o_is_mflo = 1'b1;
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_MTLO):  o_is_mtlo = 1'b1;
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_MULT): begin
                    o_is_mul    = 1'b1;
                    o_is_signed = 1'b1;
                end
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_MULTU): o_is_mul = 1'b1;
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_DIV): begin
                    o_is_div    = 1'b1;
                    o_is_signed = 1'b1;
                end
                ALU_FUNCT_BUS_WIDTH'(CODE_FUNCT_DIVU):  o_is_div = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, one shift-add or
// restoring-divide step per clock. Optional MULDIV_EARLY_TERM_EN ends a
// multiply as soon as the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int ALU_OP_BUS_WIDTH    = DEFAULT_ALU_OP_BUS_WIDTH,
    parameter int ALU_FUNCT_BUS_WIDTH = DEFAULT_ALU_FUNCT_BUS_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_valid,
    input  logic                           i_flush,
    input  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_op,
    input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
    input  logic [DATA_WIDTH-1:0]          i_rs,
    input  logic [DATA_WIDTH-1:0]          i_rt,
    output logic                           o_stall,
    output logic [DATA_WIDTH-1:0]          o_result,
    output logic [DATA_WIDTH-1:0]          o_hi,
    output logic [DATA_WIDTH-1:0]          o_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic is_mul, is_div, is_signed, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic hilo_op;

    muldiv_decoder #(
        .ALU_OP_BUS_WIDTH    (ALU_OP_BUS_WIDTH),
        .ALU_FUNCT_BUS_WIDTH (ALU_FUNCT_BUS_WIDTH)
    ) u_dec (
        .i_alu_op    (i_alu_op),
        .i_funct     (i_funct),
        .o_is_mul    (is_mul),
        .o_is_div    (is_div),
        .o_is_signed (is_signed),
        .o_is_mfhi   (is_mfhi),
        .o_is_mflo   (is_mflo),
        .o_is_mthi   (is_mthi),
        .o_is_mtlo   (is_mtlo)
    );

    assign hilo_op = i_valid & (is_mul | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo);

    state_e          state_q, state_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;

    logic            a_neg, b_neg;
    logic [W-1:0]    a_abs, b_abs;
    logic [W-1:0]    mplier_sh;
    logic [W:0]      rem_ext, diff;
    logic [2*W-1:0]  prod;
    logic            last_step, mul_done;

    assign a_neg     = is_signed & i_rs[W-1];
    assign b_neg     = is_signed & i_rt[W-1];
    assign a_abs     = a_neg ? -i_rs : i_rs;
    assign b_abs     = b_neg ? -i_rt : i_rt;
    assign mplier_sh = mplier_q >> 1;
    // Remainder shifted left with the next dividend bit brought in.
    assign rem_ext   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign diff      = rem_ext - {1'b0, mplier_q};
    assign prod      = neg_q ? -acc_q : acc_q;
    assign last_step = (cnt_q == CW'(DATA_WIDTH - 1));

`ifdef MULDIV_EARLY_TERM_EN
    assign mul_done = last_step | (mplier_sh == '0);
`else
    assign mul_done = last_step;
`endif

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        case (state_q)
            ST_IDLE: begin
                if (hilo_op && !i_flush) begin
                    if (is_mul || is_div) begin
                        state_d  = is_mul ? ST_MUL : ST_DIV;
                        mcand_d  = {{W{1'b0}}, a_abs};
                        mplier_d = b_abs;
                        acc_d    = is_mul ? '0 : {{W{1'b0}}, a_abs};
                        cnt_d    = '0;
                        is_div_d = is_div;
                        // Divide by zero keeps the all-ones quotient unsigned;
                        // the signed remainder then reproduces the raw dividend.
                        neg_d    = (a_neg ^ b_neg) & (is_mul | (i_rt != '0));
                        rneg_d   = a_neg;
                    end
                    if (is_mthi) hi_d = i_rs;
                    if (is_mtlo) lo_d = i_rs;
                end
            end
            ST_MUL: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + 1'b1;
                if (mul_done) state_d = ST_FIX;
            end
            ST_DIV: begin
                acc_d = diff[W] ? {rem_ext[W-1:0], acc_q[W-2:0], 1'b0}
                                : {diff[W-1:0],    acc_q[W-2:0], 1'b1};
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q  ? -acc_q[W-1:0]   : acc_q[W-1:0];
                    hi_d = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                end else begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_flush && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign o_stall = hilo_op & (state_q != ST_IDLE);
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

    always_comb begin
        o_result = '0;
        if (hilo_op && is_mfhi)      o_result = hi_q;
        else if (hilo_op && is_mflo) o_result = lo_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model of HI/LO,
// randomized and directed instruction streams, stall-length checks.
module tb_muldiv_unit;

    localparam logic [1:0] RT      = 2'b10;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  funct = 6'h00;
    logic [31:0] rs = '0, rt = '0;
    logic        stall;
    logic [31:0] result, hi, lo;

    muldiv_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_flush(flush),
        .i_alu_op(alu_op), .i_funct(funct), .i_rs(rs), .i_rt(rt),
        .o_stall(stall), .o_result(result), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_mf(input logic [5:0] f);
        return f == F_MFHI || f == F_MFLO;
    endfunction

    // Reference semantics of each HI/LO instruction, plain arithmetic.
    task automatic model_exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (f)
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            F_MULT: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            F_DIVU: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            F_DIV: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            default: ;
        endcase
    endtask

    function automatic int exp_busy(input logic [5:0] f, input logic [31:0] b);
        int h;
        logic [31:0] m;
        h = 31;
        m = (f == F_MULT && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_TERM_EN
        if (f == F_MULT || f == F_MULTU) begin
            h = -1;
            for (int i = 0; i < 32; i++) if (m[i]) h = i;
            if (h < 0) h = 0;
        end
`endif
        return h + 2;
    endfunction

    // Present one instruction (held while stalled); returns stall cycles.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit upd, output int stalls);
        valid = 1'b1; alu_op = RT; funct = f; rs = a; rt = b;
        stalls = 0;
        if (is_mf(f)) exp_q.push_back(f == F_MFHI ? m_hi : m_lo);
        @(negedge clk);
        while (stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200) chk("stall_timeout", 32'(stalls), 32'd0);
        if (upd && !is_mf(f)) model_exec(f, a, b);
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: any MFHI/MFLO retiring this cycle is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && valid && !flush && alu_op == RT && is_mf(funct) && !stall) begin
            if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
            else chk("mf_result", result, exp_q.pop_front());
        end
    end

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic muldiv_check(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int s;
        issue(f, a, b, 1'b1, s);
        issue(F_MFLO, 0, 0, 1'b0, s);
        chk("dep_stall_cycles", 32'(s), 32'(exp_busy(f, b)));
        issue(F_MFHI, 0, 0, 1'b0, s);
        chk("mfhi_no_stall", 32'(s), 32'd0);
    endtask

    task automatic chk_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        logic [5:0] fl[8];
        fl = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};

        #3;
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);

        // Reset asserted in the middle of a multiply.
        issue(F_MTHI, 32'hDEAD, 0, 1'b1, s);
        issue(F_MTLO, 32'hBEEF, 0, 1'b1, s);
        issue(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, s);
        idle_cycles(3);
        valid = 1'b1; alu_op = RT; funct = F_MFLO;
        #1;
        chk("busy_mflo_stalls", {31'b0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_stall", {31'b0, stall}, 32'd0);
        chk("midop_reset_hi", hi, 32'd0);
        chk("midop_reset_lo", lo, 32'd0);
        valid = 1'b0; funct = 6'h00;
        m_hi = '0; m_lo = '0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        issue(F_MTLO, 32'h1234, 0, 1'b1, s);
        issue(F_MFLO, 0, 0, 1'b0, s);
        chk("mtlo_mflo_no_stall", 32'(s), 32'd0);

        // Directed arithmetic corners.
        muldiv_check(F_MULT, 32'hFFFF_FFFD, 32'd7);
        chk_hilo("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        muldiv_check(F_DIVU, 32'd100, 32'd7);
        chk_hilo("divu_100_7", 32'd2, 32'd14);
        muldiv_check(F_DIV, 32'hFFFF_FFF9, 32'd2);
        chk_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        muldiv_check(F_DIVU, 32'd5, 32'd0);
        chk_hilo("divu_by_zero", 32'd5, 32'hFFFF_FFFF);
        muldiv_check(F_DIV, 32'hFFFF_FFF9, 32'd0);
        chk_hilo("div_neg_by_zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        muldiv_check(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_hilo("div_min_m1", 32'd0, 32'h8000_0000);
        muldiv_check(F_MULTU, 32'd5, 32'd3);
        chk_hilo("multu_5x3", 32'd0, 32'd15);
        muldiv_check(F_MULTU, 32'd9, 32'd0);

        // Unrelated instruction while busy does not stall.
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, s);
        issue(F_ADD, 32'd1, 32'd2, 1'b0, s);
        chk("nonhilo_no_stall", 32'(s), 32'd0);
        issue(F_MFHI, 0, 0, 1'b0, s);
        chk("mfhi_after_add_stall", 32'(s), 32'(exp_busy(F_MULTU, 32'hFFFF_FFFF) - 1));

        // Flush on busy cycle 5: HI/LO untouched, unit idle.
        issue(F_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, s);
        idle_cycles(4);
        flush = 1'b1;
        idle_cycles(1);
        flush = 1'b0;
        issue(F_MFHI, 0, 0, 1'b0, s);
        chk("flush_mfhi_no_stall", 32'(s), 32'd0);
        issue(F_MFLO, 0, 0, 1'b0, s);

        // Flush concurrent with a start: start ignored.
        valid = 1'b1; alu_op = RT; funct = F_DIVU; rs = 32'd77; rt = 32'd3; flush = 1'b1;
        idle_cycles(1);
        valid = 1'b0; flush = 1'b0; funct = 6'h00;
        issue(F_MFLO, 0, 0, 1'b0, s);
        chk("flush_start_no_stall", 32'(s), 32'd0);

        // Randomized instruction stream.
        for (int it = 0; it < 60; it++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = fl[$urandom_range(0, 7)];
            a = pick_val();
            b = pick_val();
            if (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) muldiv_check(f, a, b);
            else issue(f, a, b, 1'b1, s);
        end

        idle_cycles(2);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage beside the ALU. It decodes R-type funct for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and runs one shift-add or restore step per clock. It raises a stall to the hazard unit when a dependent HI/LO instruction arrives while an operation is in flight. It generalises the single-cycle ALU control decode with width parametrisation, sequencing and flush handling.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width
ALU_OP_BUS_WIDTH, DEFAULT_ALU_OP_BUS_WIDTH, width of i_alu_op
ALU_FUNCT_BUS_WIDTH, DEFAULT_ALU_FUNCT_BUS_WIDTH, width of i_funct

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_valid  input  1  EX-stage instruction valid
i_flush  input  1  pipeline flush; abort in-flight operation
i_alu_op  input  ALU_OP_BUS_WIDTH  main-control ALU op; unit acts only on CODE_ALU_CTR_R_TYPE
i_funct  input  ALU_FUNCT_BUS_WIDTH  instruction funct
i_rs  input  DATA_WIDTH  operand A (dividend/multiplicand, MTHI/MTLO source)
i_rt  input  DATA_WIDTH  operand B (divisor/multiplier)
o_stall  output  1  hold IF/ID/EX this cycle
o_result  output  DATA_WIDTH  HI (MFHI) or LO (MFLO), else 0
o_hi  output  DATA_WIDTH  HI register
o_lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset (i_reset=0, async): state IDLE, HI=LO=0, counter=0, o_stall=0, o_result=0.
- Decode: hilo_op = i_valid & R_TYPE & funct in {0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU}.
- o_stall = hilo_op & (state != IDLE), combinational. Non-HI/LO instructions never stall.
- FSM: IDLE, MUL, DIV, FIX.
- IDLE, MULT/MULTU accepted (hilo_op, !i_flush) -> MUL. Latch |operands| for signed, raw values for unsigned, and the result-sign flags. Clear the 2*DATA_WIDTH accumulator; counter=0.
- IDLE, DIV/DIVU -> DIV, latched the same way.
- MUL step: if multiplier LSB, acc += multiplicand (2*DATA_WIDTH). Then multiplicand <<= 1, multiplier >>= 1, counter++. When counter reaches DATA_WIDTH-1 -> FIX.
- DIV step: restoring, one quotient bit per cycle, MSB first. After DATA_WIDTH steps -> FIX.
- FIX (1 cycle): apply signs. Product is negated if signs differ. Quotient is negated if signs differ; remainder takes the dividend sign. Write HI/LO, then -> IDLE.
- Latency: o_stall (for dependent ops) covers DATA_WIDTH+1 cycles after acceptance. HI/LO are visible on the cycle after FIX.
- Divide by zero: no trap. LO = all ones, HI = dividend (raw i_rs), same latency.
- Signed corner: DIV most-negative/-1 gives LO = most-negative, HI = 0.
- MTHI/MTLO in IDLE: write next edge, no stall.
- MFHI/MFLO in IDLE: o_result is combinational from the current HI/LO.
- Same-edge MTxx and FIX write cannot occur, because MTxx stalls while busy.
- i_flush in any non-IDLE state: -> IDLE next edge, HI/LO unchanged.
- i_flush concurrent with a start: start is ignored.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: in MUL, when the shifted multiplier becomes zero after a step, go -> FIX immediately. Busy cycles = index of the highest set bit of |multiplier| + 2. A multiplier of 0 gives 1 step + FIX.
- Undefined: fixed DATA_WIDTH steps. Results are identical either way; only latency differs.

Decomposition:
- muldiv.vh holds:
  - funct codes CODE_FUNCT_MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU
  - FSM state encodings and STATE_BUS_WIDTH
  - DEFAULT_DATA_WIDTH
- The R-type alu_op code is taken from alu_control.vh.
- Sub-module muldiv_decoder (combinational): funct/alu_op -> one-hot {is_mul, is_div, is_signed, is_mfhi, is_mflo, is_mthi, is_mtlo}.

Test Plan:
- Reset low mid-MUL -> o_stall=0, HI=LO=0 immediately. After release, MTLO 0x1234 then MFLO -> o_result=0x00001234.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO issued 1 cycle later stalls until then.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0x10000/0x10000, then i_flush at busy cycle 5 -> state IDLE, HI/LO keep their previous values, and a following MFHI does not stall.
- With MULDIV_EARLY_TERM_EN: MULTU 5*3 -> LO=15, HI=0, stall lasts 3 cycles (2 steps + FIX). Without the macro it lasts 33.
